rv64g_l1_alloc_ctrl: RTL and testbench
======================================

Name: rv64g_l1_alloc_ctrl

Overview:
- Miss-allocation sequencer for the 8-way L1; sits directly upstream of the PLRU block.
- Accepts one miss at a time, drives the set index to PLRU and tag array, and samples the returned victim.
- Writes the victim back if it is dirty, acquires the line (multi-beat grant), installs it, then issues the PLRU touch for the installed way.
- Also forwards hit-path PLRU touches when the FSM does not own the PLRU port.

Parameters:
- SETS, 32, number of sets
- INDEX_W, 5, set index width
- TAG_W, 20, tag width
- BEATS, 4, grant data beats per line (power of 2, ≥1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- miss_valid_i  in  1  miss request valid
- miss_ready_o  out  1  accept miss (high only in IDLE)
- miss_set_i  in  INDEX_W  miss set
- miss_tag_i  in  TAG_W  miss tag
- hit_valid_i  in  1  hit-path PLRU touch
- hit_set_i  in  INDEX_W  hit set
- hit_way_i  in  3  hit way
- hit_stall_o  out  1  hit touch rejected this cycle
- plru_set_o  out  INDEX_W  PLRU / tag-array set index
- plru_access_o  out  1  PLRU update strobe
- plru_way_o  out  3  PLRU used way
- plru_victim_i  in  3  victim from PLRU (combinational on plru_set_o)
- dirty_i  in  8  dirty mask of set plru_set_o
- wb_valid_o / wb_ready_i  out/in  1/1  writeback request handshake
- wb_set_o, wb_way_o  out  INDEX_W/3  writeback target
- wb_done_i  in  1  writeback complete pulse
- acq_valid_o / acq_ready_i  out/in  1/1  acquire request handshake
- acq_set_o, acq_tag_o  out  INDEX_W/TAG_W  acquire address
- gnt_valid_i  in  1  grant beat valid (no backpressure)
- inst_valid_o  out  1  one-cycle tag/valid/dirty=0 install strobe
- inst_set_o, inst_way_o, inst_tag_o  out  —  install target
- done_o  out  1  one-cycle miss-complete pulse
- err_o  out  1  sticky timeout error (feature only, else tied 0)

Behaviour:
- Reset values: state=IDLE, beat counter=0; miss_ready_o=1; every other output 0, including the held set, way and tag registers.
- States:
  - IDLE: on miss_valid_i&&miss_ready_o, capture set/tag and go to LOOKUP.
  - LOOKUP (1 cycle): plru_set_o=captured set; capture vway=plru_victim_i and vdirty=dirty_i[plru_victim_i]. Go to WB_REQ if vdirty, else ACQ_REQ.
  - WB_REQ: wb_valid_o=1, held until wb_ready_i, then WB_WAIT.
  - WB_WAIT: on wb_done_i go to ACQ_REQ.
  - ACQ_REQ: acq_valid_o=1, held until acq_ready_i, then GNT.
  - GNT: count gnt_valid_i beats; on beat BEATS-1 go to INSTALL. Counter wraps to 0.
  - INSTALL (1 cycle): inst_valid_o=1, plru_access_o=1, plru_way_o=vway, plru_set_o=captured set. Go to RESP.
  - RESP (1 cycle): done_o=1, then IDLE.
- Minimum miss latency, clean victim, ready and grant immediate: accept → done_o = 4+BEATS cycles.
- Request payloads stay stable while valid is high; valid never drops before ready.
- PLRU port ownership:
  - In LOOKUP and INSTALL the FSM owns the port. hit_stall_o = hit_valid_i, and the hit touch is dropped; the hit source must retry.
  - In all other states plru_set_o=hit_set_i, plru_access_o=hit_valid_i, plru_way_o=hit_way_i.
- wb_done_i outside WB_WAIT, gnt_valid_i outside GNT, and a wb_ready_i/acq_ready_i seen without its matching valid are all ignored.
- Reset asserted mid-sequence returns the FSM to IDLE next edge with every output at its reset value. Partial grant beats are discarded.
- Victim selection and the invalid-first preference are owned by PLRU; this block does not inspect valid bits.

Optional Feature:
- Macro RV64G_L1_ALLOC_TIMEOUT_EN.
- With the macro: a 10-bit watchdog counter runs in WB_WAIT and GNT and clears on every state change or beat. When it reaches 1023, err_o sets sticky (cleared only by rst_i) and the FSM forces IDLE without install or done_o.
- Without the macro: no counter; err_o tied 0; waits are unbounded.

Decomposition:
- Shared package rv64g_l1_pkg:
  - FSM state enum (3-bit encoding)
  - NUM_WAYS=8 and WAY_W=3
  - beat-counter width function clog2(BEATS)
- No sub-module needed. The watchdog stays inline under the macro guard.

Test Plan:
- Clean miss: set 5, tag 0x1234, victim 3, dirty 0x00, BEATS=4 grants back-to-back → no wb_valid_o; inst_valid_o way 3 set 5 tag 0x1234; plru_access_o way 3 same cycle; done_o 8 cycles after accept.
- Dirty miss: victim 6, dirty 0x40, wb_ready_i delayed 3 cycles, wb_done_i 5 cycles later → wb_set_o=set, wb_way_o=6 held stable; acq_valid_o only after wb_done_i.
- Gapped grants: beats on cycles 0, 2, 3, 7 → INSTALL exactly one cycle after beat 4; a spurious gnt_valid_i in ACQ_REQ is ignored.
- Hit collision: hit_valid_i set 9 way 1 during INSTALL → hit_stall_o=1, plru_way_o=victim. The same hit in GNT → forwarded with no stall.
- Reset in GNT after 2 beats → next cycle IDLE, miss_ready_o=1, all other outputs 0. A new miss completes with the full 4 beats.
- Timeout (macro on): no wb_done_i for 1023 cycles → err_o=1 sticky, FSM in IDLE, done_o never pulses.

Source files
------------

// File: rtl/rv64g_l1_pkg.sv
// rv64g_l1_pkg: shared types and constants for the L1 miss-allocation path.
//   state_e     - allocation FSM state (3-bit encoding)
//   NUM_WAYS    - associativity of the L1 (8)
//   WAY_W       - way index width (3)
//   clog2       - ceiling log2 for elaboration-time widths
//   beat_cnt_w  - grant beat counter width, never narrower than 1 bit
package rv64g_l1_pkg;

    localparam int NUM_WAYS = 8;
    localparam int WAY_W    = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB_REQ,
        S_WB_WAIT,
        S_ACQ_REQ,
        S_GNT,
        S_INSTALL,
        S_RESP
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < n) r++;
        return r;
    endfunction

    // A single-beat line still needs a 1-bit counter to keep the logic legal.
    function automatic int beat_cnt_w(input int beats);
        return (clog2(beats) < 1) ? 1 : clog2(beats);
    endfunction

endpackage

// File: rtl/rv64g_l1_alloc_ctrl.sv
// rv64g_l1_alloc_ctrl: miss-allocation sequencer for the 8-way L1, upstream of the PLRU.
//   Accepts one miss at a time, looks up the PLRU victim, writes it back when dirty,
//   acquires the new line over a multi-beat grant, installs it and touches the PLRU.
//   Hit-path PLRU touches are forwarded whenever the FSM does not own the PLRU port.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   miss_valid_i/miss_ready_o          miss handshake (ready only in IDLE)
//   miss_set_i, miss_tag_i             miss address
//   hit_valid_i, hit_set_i, hit_way_i  hit-path PLRU touch; hit_stall_o when dropped
//   plru_set_o, plru_access_o, plru_way_o  PLRU / tag-array port
//   plru_victim_i, dirty_i             victim and dirty mask for plru_set_o
//   wb_*                               victim writeback request and completion
//   acq_*, gnt_valid_i                 line acquire request and grant beats
//   inst_*                             one-cycle install strobe and target
//   done_o                             one-cycle miss-complete pulse
//   err_o                              sticky watchdog timeout
// Build option: RV64G_L1_ALLOC_TIMEOUT_EN enables a 1023-cycle watchdog on WB_WAIT and GNT;
//   without it err_o is tied low and the waits are unbounded.
module rv64g_l1_alloc_ctrl
    import rv64g_l1_pkg::*;
#(
    parameter int SETS    = 32,
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 20,
    parameter int BEATS   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               miss_valid_i,
    output logic               miss_ready_o,
    input  logic [INDEX_W-1:0] miss_set_i,
    input  logic [TAG_W-1:0]   miss_tag_i,
    input  logic               hit_valid_i,
    input  logic [INDEX_W-1:0] hit_set_i,
    input  logic [2:0]         hit_way_i,
    output logic               hit_stall_o,
    output logic [INDEX_W-1:0] plru_set_o,
    output logic               plru_access_o,
    output logic [2:0]         plru_way_o,
    input  logic [2:0]         plru_victim_i,
    input  logic [7:0]         dirty_i,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [INDEX_W-1:0] wb_set_o,
    output logic [2:0]         wb_way_o,
    input  logic               wb_done_i,
    output logic               acq_valid_o,
    input  logic               acq_ready_i,
    output logic [INDEX_W-1:0] acq_set_o,
    output logic [TAG_W-1:0]   acq_tag_o,
    input  logic               gnt_valid_i,
    output logic               inst_valid_o,
    output logic [INDEX_W-1:0] inst_set_o,
    output logic [2:0]         inst_way_o,
    output logic [TAG_W-1:0]   inst_tag_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int CNT_W = beat_cnt_w(BEATS);

    if (SETS > (1 << INDEX_W) || BEATS < 1 || (BEATS & (BEATS - 1)) != 0) begin : g_param_chk
        $error("rv64g_l1_alloc_ctrl: SETS must fit INDEX_W and BEATS must be a power of 2");
    end

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] set_q;
    logic [TAG_W-1:0]   tag_q;
    logic [WAY_W-1:0]   vway_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_beat;
    logic               own;
    logic               timeout;

    assign last_beat = gnt_valid_i && (cnt_q == CNT_W'(BEATS - 1));

`ifdef RV64G_L1_ALLOC_TIMEOUT_EN
    logic [9:0] wdog_q;
    logic       err_q;

    assign timeout = (wdog_q == 10'd1023);
    assign err_o   = err_q;

    // Any progress (state change or grant beat) restarts the watchdog.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (timeout) err_q <= 1'b1;
            wdog_q <= (state_d != state_q || (state_q == S_GNT && gnt_valid_i) ||
                       !(state_q inside {S_WB_WAIT, S_GNT})) ? '0 : wdog_q + 10'd1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (miss_valid_i) state_d = S_LOOKUP;
            S_LOOKUP:  state_d = dirty_i[plru_victim_i] ? S_WB_REQ : S_ACQ_REQ;
            S_WB_REQ:  if (wb_ready_i) state_d = S_WB_WAIT;
            S_WB_WAIT: if (wb_done_i) state_d = S_ACQ_REQ;
            S_ACQ_REQ: if (acq_ready_i) state_d = S_GNT;
            S_GNT:     if (last_beat) state_d = S_INSTALL;
            S_INSTALL: state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            set_q   <= '0;
            tag_q   <= '0;
            vway_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && miss_valid_i) begin
                set_q <= miss_set_i;
                tag_q <= miss_tag_i;
            end
            if (state_q == S_LOOKUP) vway_q <= plru_victim_i;
            if (state_q != S_GNT) cnt_q <= '0;
            else if (gnt_valid_i) cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
        end
    end

    // LOOKUP and INSTALL own the PLRU port; any hit touch then is dropped and must retry.
    assign own           = (state_q == S_LOOKUP) || (state_q == S_INSTALL);
    assign hit_stall_o   = own && hit_valid_i;
    assign plru_set_o    = own ? set_q : hit_set_i;
    assign plru_way_o    = own ? vway_q : hit_way_i;
    assign plru_access_o = (state_q == S_INSTALL) || (!own && hit_valid_i);

    assign miss_ready_o  = (state_q == S_IDLE);
    assign wb_valid_o    = (state_q == S_WB_REQ);
    assign acq_valid_o   = (state_q == S_ACQ_REQ);
    assign inst_valid_o  = (state_q == S_INSTALL);
    assign done_o        = (state_q == S_RESP);

    assign wb_set_o      = set_q;
    assign wb_way_o      = vway_q;
    assign acq_set_o     = set_q;
    assign acq_tag_o     = tag_q;
    assign inst_set_o    = set_q;
    assign inst_way_o    = vway_q;
    assign inst_tag_o    = tag_q;

endmodule

// File: tb/tb_rv64g_l1_alloc_ctrl.sv
// tb_rv64g_l1_alloc_ctrl: self-checking bench for the L1 miss-allocation sequencer.
module tb_rv64g_l1_alloc_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        miss_valid_i, miss_ready_o;
    logic [4:0]  miss_set_i;
    logic [19:0] miss_tag_i;
    logic        hit_valid_i;
    logic [4:0]  hit_set_i;
    logic [2:0]  hit_way_i;
    logic        hit_stall_o;
    logic [4:0]  plru_set_o;
    logic        plru_access_o;
    logic [2:0]  plru_way_o, plru_victim_i;
    logic [7:0]  dirty_i;
    logic        wb_valid_o, wb_ready_i, wb_done_i;
    logic [4:0]  wb_set_o;
    logic [2:0]  wb_way_o;
    logic        acq_valid_o, acq_ready_i;
    logic [4:0]  acq_set_o;
    logic [19:0] acq_tag_o;
    logic        gnt_valid_i;
    logic        inst_valid_o;
    logic [4:0]  inst_set_o;
    logic [2:0]  inst_way_o;
    logic [19:0] inst_tag_o;
    logic        done_o, err_o;

    int n_chk = 0;
    int n_fail = 0;

    logic [4:0] cur_set;
    logic [2:0] cur_vic;
    logic [7:0] cur_dm;

    always #5 clk_i = ~clk_i;

    // PLRU / tag-array stand-in: only the set under allocation returns the planned victim.
    assign plru_victim_i = (plru_set_o == cur_set) ? cur_vic : ~cur_vic;
    assign dirty_i       = (plru_set_o == cur_set) ? cur_dm : ~cur_dm;

    rv64g_l1_alloc_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
        .miss_set_i(miss_set_i), .miss_tag_i(miss_tag_i),
        .hit_valid_i(hit_valid_i), .hit_set_i(hit_set_i), .hit_way_i(hit_way_i),
        .hit_stall_o(hit_stall_o),
        .plru_set_o(plru_set_o), .plru_access_o(plru_access_o), .plru_way_o(plru_way_o),
        .plru_victim_i(plru_victim_i), .dirty_i(dirty_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_set_o(wb_set_o), .wb_way_o(wb_way_o), .wb_done_i(wb_done_i),
        .acq_valid_o(acq_valid_o), .acq_ready_i(acq_ready_i),
        .acq_set_o(acq_set_o), .acq_tag_o(acq_tag_o),
        .gnt_valid_i(gnt_valid_i),
        .inst_valid_o(inst_valid_o), .inst_set_o(inst_set_o),
        .inst_way_o(inst_way_o), .inst_tag_o(inst_tag_o),
        .done_o(done_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        miss_valid_i = 0; miss_set_i = 0; miss_tag_i = 0;
        hit_valid_i = 0; hit_set_i = 0; hit_way_i = 0;
        wb_ready_i = 0; wb_done_i = 0; acq_ready_i = 0; gnt_valid_i = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {miss_ready_o, wb_valid_o, acq_valid_o, inst_valid_o,
                            done_o, hit_stall_o, plru_access_o, err_o}, 8'b1000_0000);
        chk({tag, "_data"}, {wb_set_o, wb_way_o, acq_set_o, acq_tag_o, inst_set_o,
                             inst_way_o, inst_tag_o, plru_set_o, plru_way_o}, 0);
    endtask

    // One miss against a planned environment timeline. Cycle 0 is the accept cycle;
    // every later phase boundary follows from the handshake delays and grant positions.
    task automatic run_miss(input logic [4:0] set, input logic [19:0] tag, input logic [2:0] vic,
                            input logic [7:0] dm, input int rdly, input int ddly, input int adly,
                            input int g0, input int g1, input int g2, input int g3,
                            input bit fixed_hit);
        bit d, own;
        int wb_hs, wbd, acq_s, acq_hs, gs, inst_c, done_c;
        logic [6:0] exp_ctl;
        d      = dm[vic];
        wb_hs  = 2 + rdly;
        wbd    = wb_hs + ddly + 1;
        acq_s  = d ? wbd + 1 : 2;
        acq_hs = acq_s + adly;
        gs     = acq_hs + 1;
        inst_c = gs + g3 + 1;
        done_c = inst_c + 1;
        cur_set = set; cur_vic = vic; cur_dm = dm;
        for (int c = 0; c <= done_c + 1; c++) begin
            miss_valid_i = (c == 0) || (c <= done_c && $urandom_range(0, 1) == 1);
            miss_set_i   = (c == 0) ? set : 5'($urandom);
            miss_tag_i   = (c == 0) ? tag : 20'($urandom);
            wb_ready_i   = (d && c >= 2 && c <= wb_hs) ? (c == wb_hs) : 1'($urandom);
            wb_done_i    = (d && c > wb_hs && c <= wbd) ? (c == wbd) : 1'($urandom);
            acq_ready_i  = (c >= acq_s && c <= acq_hs) ? (c == acq_hs) : 1'($urandom);
            gnt_valid_i  = (c >= gs && c < inst_c) ? ((c - gs) inside {g0, g1, g2, g3}) : 1'($urandom);
            hit_valid_i  = fixed_hit | 1'($urandom);
            hit_set_i    = fixed_hit ? 5'd9 : 5'($urandom);
            hit_way_i    = fixed_hit ? 3'd1 : 3'($urandom);
            #1;
            own = (c == 1) || (c == inst_c);
            exp_ctl = {c == 0 || c > done_c, d && c >= 2 && c <= wb_hs, c >= acq_s && c <= acq_hs,
                       c == inst_c, c == done_c, own && hit_valid_i,
                       c == inst_c || (!own && hit_valid_i)};
            chk("ctl", {miss_ready_o, wb_valid_o, acq_valid_o, inst_valid_o, done_o,
                        hit_stall_o, plru_access_o}, exp_ctl);
            chk("plru_set", plru_set_o, own ? set : hit_set_i);
            if (c != 1) chk("plru_way", plru_way_o, (c == inst_c) ? vic : hit_way_i);
            if (exp_ctl[5]) chk("wb_tgt", {wb_set_o, wb_way_o}, {set, vic});
            if (exp_ctl[4]) chk("acq_addr", {acq_set_o, acq_tag_o}, {set, tag});
            if (exp_ctl[3]) chk("inst_tgt", {inst_set_o, inst_way_o, inst_tag_o}, {set, vic, tag});
            chk("err", err_o, 1'b0);
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        int g0, g1, g2, g3;
        idle_inputs();
        cur_set = 0; cur_vic = 0; cur_dm = 0;
        rst_i = 1;
        cyc();
        cyc();
        chk_reset("rst_init");
        rst_i = 0;

        run_miss(5'd5, 20'h01234, 3'd3, 8'h00, 0, 0, 0, 0, 1, 2, 3, 0);
        run_miss(5'd12, 20'h0beef, 3'd6, 8'h40, 3, 5, 0, 0, 1, 2, 3, 0);
        run_miss(5'd10, 20'h00055, 3'd1, 8'hfd, 0, 0, 2, 0, 2, 3, 7, 0);
        run_miss(5'd20, 20'hfffff, 3'd4, 8'h00, 0, 0, 0, 0, 1, 2, 3, 1);
        run_miss(5'd31, 20'h80001, 3'd7, 8'h80, 0, 0, 0, 1, 3, 4, 5, 1);

        // Reset after two grant beats: the partial line must be forgotten.
        idle_inputs();
        cur_set = 5'd7; cur_vic = 3'd2; cur_dm = 8'h00;
        miss_valid_i = 1; miss_set_i = 5'd7; miss_tag_i = 20'habc;
        cyc();
        miss_valid_i = 0;
        cyc();
        acq_ready_i = 1;
        cyc();
        acq_ready_i = 0;
        gnt_valid_i = 1;
        cyc();
        cyc();
        gnt_valid_i = 0;
        rst_i = 1;
        cyc();
        rst_i = 0;
        chk_reset("rst_mid");
        run_miss(5'd7, 20'h00abc, 3'd2, 8'h00, 0, 0, 0, 0, 1, 2, 3, 0);

        for (int i = 0; i < 16; i++) begin
            g0 = $urandom_range(0, 2);
            g1 = g0 + 1 + $urandom_range(0, 2);
            g2 = g1 + 1 + $urandom_range(0, 2);
            g3 = g2 + 1 + $urandom_range(0, 2);
            run_miss(5'($urandom), 20'($urandom), 3'($urandom), 8'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                     g0, g1, g2, g3, 1'($urandom));
        end

`ifdef RV64G_L1_ALLOC_TIMEOUT_EN
        begin
            bit saw_done;
            saw_done = 0;
            idle_inputs();
            cur_set = 5'd3; cur_vic = 3'd5; cur_dm = 8'h20;
            miss_valid_i = 1; miss_set_i = 5'd3; miss_tag_i = 20'h1;
            cyc();
            miss_valid_i = 0;
            wb_ready_i = 1;
            cyc();
            for (int i = 0; i < 1200 && !miss_ready_o; i++) begin
                cyc();
                if (done_o) saw_done = 1;
            end
            wb_ready_i = 0;
            chk("to_idle", miss_ready_o, 1'b1);
            chk("to_done", saw_done, 1'b0);
            chk("to_err", err_o, 1'b1);
            cyc();
            cyc();
            chk("to_sticky", err_o, 1'b1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
